// File: rtl/uart_cmd_ctrl.sv
// UART command controller.
// Parses 4-byte frames {SYNC_BYTE, ADDR, DATA, CHK} from a UART receiver and
// issues a one-cycle register-write strobe when CHK == ADDR + DATA (mod 256).
// A bad checksum or an inter-byte gap longer than TIMEOUT_CLKS abandons the
// frame and raises a one-cycle error pulse. All outputs are registered.
//
// Handshake: i_Rx_DV is a one-cycle valid pulse with no ready. Every pulse is
// consumed on the rising edge where it is sampled; there is no back-pressure.
// In GET_ADDR/GET_DATA/GET_CHK every byte is accepted. In IDLE and WRITE only
// SYNC_BYTE starts a frame and other bytes are dropped.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 3480
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_Stb,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Busy,
  output logic       o_Err_Chk,
  output logic       o_Err_Tmo,
  output logic [7:0] o_Frame_Cnt,
  output logic [2:0] o_Dbg_State
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    WRITE    = 3'd4
  } state_t;

  // Last counter value before the frame is abandoned.
  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CLKS - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic [11:0] tmo_cnt;

  logic [7:0]  chk_sum;
  logic        chk_ok;
  logic        in_frame;
  logic        tmo_hit;
  logic        wr_d;
  logic        busy_d;
  logic        err_chk_d;
  logic        err_tmo_d;

  // Debug view of the FSM.
  assign o_Dbg_State = state;

  // Frame-level conditions. A DV in the timeout cycle wins over the timeout.
  always_comb begin
    chk_sum  = addr_q + data_q;
    chk_ok   = (chk_sum == i_Rx_Byte);
    in_frame = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CHK);
    tmo_hit  = in_frame && (tmo_cnt == TMO_LAST) && !i_Rx_DV;
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic. WRITE treats an incoming byte exactly as IDLE does.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) next_state = GET_ADDR;
      end
      GET_ADDR: begin
        if (i_Rx_DV)      next_state = GET_DATA;
        else if (tmo_hit) next_state = IDLE;
      end
      GET_DATA: begin
        if (i_Rx_DV)      next_state = GET_CHK;
        else if (tmo_hit) next_state = IDLE;
      end
      GET_CHK: begin
        if (i_Rx_DV)      next_state = chk_ok ? WRITE : IDLE;
        else if (tmo_hit) next_state = IDLE;
      end
      WRITE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) next_state = GET_ADDR;
        else                                     next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    wr_d      = (state == WRITE);
    busy_d    = (next_state != IDLE);
    err_chk_d = (state == GET_CHK) && i_Rx_DV && !chk_ok;
    err_tmo_d = tmo_hit;
  end

  // Captured ADDR/DATA bytes of the frame in progress.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if ((state == GET_ADDR) && i_Rx_DV) addr_q <= i_Rx_Byte;
      if ((state == GET_DATA) && i_Rx_DV) data_q <= i_Rx_Byte;
    end
  end

  // Inter-byte timer: runs only inside a frame, restarts on every byte.
  // It is zero whenever the FSM enters GET_ADDR since it idles at zero.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n)                tmo_cnt <= '0;
    else if (!in_frame || i_Rx_DV) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 12'd1;
  end

  // Registered outputs. Write results land one edge after WRITE is entered.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Wr_Stb    <= 1'b0;
      o_Wr_Addr   <= '0;
      o_Wr_Data   <= '0;
      o_Busy      <= 1'b0;
      o_Err_Chk   <= 1'b0;
      o_Err_Tmo   <= 1'b0;
      o_Frame_Cnt <= '0;
    end else begin
      o_Wr_Stb  <= wr_d;
      o_Busy    <= busy_d;
      o_Err_Chk <= err_chk_d;
      o_Err_Tmo <= err_tmo_d;
      if (wr_d) begin
        o_Wr_Addr   <= addr_q;
        o_Wr_Data   <= data_q;
        o_Frame_Cnt <= o_Frame_Cnt + 8'd1;
      end
    end
  end

endmodule
